ahb3lite_fault_slave: RTL and testbench
=======================================

# ahb3lite_fault_slave

Parametrised AHB3-Lite default slave that completes every access not claimed by another slave, with a configurable number of wait states, a selectable response mode (two-cycle ERROR or OKAY read-as-constant/write-ignored), and a fault capture unit that records the first unclaimed access and counts all of them. It sits on the default-slave port of the AHB3-Lite interconnect decoder. Its fault outputs feed a system status register or interrupt controller.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HRDATA width
- WAIT_STATES, 0, extra data-phase wait cycles inserted before the response (0..15)
- ERR_MODE, 1, 1 = ERROR response; 0 = OKAY response (reads return RDATA_VALUE, writes ignored)
- RDATA_VALUE, 0, constant driven on HRDATA
- CNT_WIDTH, 8, fault counter width
- CLK  in  1  bus clock
- RESETn  in  1  reset; asynchronous, active-low
- HSEL  in  1  default-slave select from decoder
- HADDR  in  ADDR_WIDTH  address phase address
- HWRITE  in  1  address phase direction
- HSIZE  in  3  address phase size
- HTRANS  in  2  transfer type
- HREADY  in  1  bus ready (previous transfer complete)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  DATA_WIDTH  read data
- fault_clr  in  1  single-cycle pulse: clears fault capture and counter
- fault_valid  out  1  first fault captured; also the interrupt level
- fault_ovf  out  1  at least one further fault completed while fault_valid = 1
- fault_addr  out  ADDR_WIDTH  HADDR of captured fault
- fault_write  out  1  HWRITE of captured fault
- fault_size  out  3  HSIZE of captured fault
- fault_count  out  CNT_WIDTH  number of completed unclaimed transfers, saturating

## Operation
- Accept condition: HSEL & HREADY & HTRANS in {NONSEQ, SEQ}. IDLE and BUSY are never accepted. Any transfer presented while HREADY = 0 is never accepted.
- On accept, latch HADDR, HWRITE and HSIZE into pending registers.
- States: IDLE, WAIT, ERR1, ERR2, OKAY.
- IDLE on accept: go to WAIT if WAIT_STATES > 0. Otherwise go to ERR1 (ERR_MODE = 1) or OKAY (ERR_MODE = 0).
- WAIT: an internal counter loads WAIT_STATES-1 on entry and decrements each cycle. At 0, go to ERR1 or OKAY.
- ERR1 → ERR2 unconditionally.
- ERR2 and OKAY are completion cycles. If the accept condition is true in this cycle, start the next transfer immediately, exactly as from IDLE. Otherwise go to IDLE.
- Registered outputs per state, for the cycle after the state is entered:
  - IDLE: HREADYOUT=1, HRESP=0
  - WAIT: HREADYOUT=0, HRESP=0
  - ERR1: HREADYOUT=0, HRESP=1
  - ERR2: HREADYOUT=1, HRESP=1
  - OKAY: HREADYOUT=1, HRESP=0
- HRDATA = RDATA_VALUE at all times.
- Writes have no side effect other than fault capture.
- Fault capture fires at each completion edge (leaving ERR2 or OKAY), in both modes:
  - fault_count increments and saturates at 2^CNT_WIDTH-1.
  - If fault_valid = 0: load fault_addr, fault_write and fault_size from the pending registers, and set fault_valid.
  - Else set fault_ovf.
- fault_clr clears fault_valid, fault_ovf and fault_count. fault_addr, fault_write and fault_size hold their values.
- fault_clr on the same edge as a completion: the clear applies first, then the completion is recorded. Result: fault_valid=1, fault_ovf=0, fault_count=1, new fault captured.

## Timing
- Reset values (async assert, applied to every register): state IDLE, HREADYOUT=1, HRESP=0, fault_valid=0, fault_ovf=0, fault_count=0, fault_addr=0, fault_write=0, fault_size=0.
- Accept on edge T. With W = WAIT_STATES:
  - ERR_MODE=1: data phase lasts W+2 cycles. Cycles T..T+W-1 have HREADYOUT=0/HRESP=0. Cycle T+W has 0/1. Cycle T+W+1 has 1/1.
  - ERR_MODE=0: data phase lasts W+1 cycles, ending with 1/0.
- Fault outputs update on the completion edge and are visible the following cycle.
- Back-to-back accepts are supported with no idle cycle between data phases.
- HSEL deassertion mid-response does not abort the response; the response runs to completion.
- RESETn assertion mid-response forces IDLE immediately. The pending fault is not recorded.

## Test plan
- ERR_MODE=1, W=0, single NONSEQ read to 0x4000_0010 → HREADYOUT/HRESP = 0/1 then 1/1. Then fault_valid=1, fault_addr=0x4000_0010, fault_write=0, fault_count=1.
- ERR_MODE=1, W=3, write with HSIZE=2 → three 0/0 cycles, then 0/1, then 1/1. fault_write=1, fault_size=2.
- ERR_MODE=0, W=2, RDATA_VALUE=0xDEADBEEF, read → two wait cycles, then 1/0 with HRDATA=0xDEADBEEF. The fault is still recorded.
- Two back-to-back NONSEQ transfers to 0x100 and 0x200 → no idle gap between data phases. fault_addr=0x100, fault_ovf=1, fault_count=2.
- CNT_WIDTH=2, five faults → fault_count saturates at 3. fault_clr pulsed on the completion edge of a sixth fault → fault_count=1, fault_ovf=0, fault_valid=1, fault_addr = sixth address.
- IDLE/BUSY transfers, HSEL=0, or HREADY=0 → no response change and no count change. RESETn low during ERR1 → outputs return to 1/0 asynchronously and fault_count stays 0.

Source files
------------

// File: rtl/ahb3lite_fault_slave.sv
// ahb3lite_fault_slave: AHB3-Lite default slave with wait states, ERROR/OKAY response mode
// and first-fault capture plus a saturating count of unclaimed accesses.
module ahb3lite_fault_slave #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    WAIT_STATES = 0,
   parameter bit                    ERR_MODE    = 1'b1,
   parameter logic [DATA_WIDTH-1:0] RDATA_VALUE = '0,
   parameter int                    CNT_WIDTH   = 8
) (
   input  logic                  CLK,
   input  logic                  RESETn,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [1:0]            HTRANS,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [DATA_WIDTH-1:0] HRDATA,
   input  logic                  fault_clr,
   output logic                  fault_valid,
   output logic                  fault_ovf,
   output logic [ADDR_WIDTH-1:0] fault_addr,
   output logic                  fault_write,
   output logic [2:0]            fault_size,
   output logic [CNT_WIDTH-1:0]  fault_count
);
   typedef enum logic [2:0] {IDLE, WAIT, ERR1, ERR2, OKAY} state_t;

   localparam state_t     RESP_ST   = state_t'(ERR_MODE ? ERR1 : OKAY);
   localparam state_t     FIRST_ST  = state_t'((WAIT_STATES > 0) ? WAIT : RESP_ST);
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t                state, next;
   logic [3:0]            wait_cnt;
   logic [ADDR_WIDTH-1:0] pend_addr;
   logic                  pend_write;
   logic [2:0]            pend_size;
   logic                  complete, start, keep_valid;
   logic [CNT_WIDTH-1:0]  cnt_base;

   assign complete   = (state == ERR2) || (state == OKAY);
   // only IDLE and completion cycles may start a transfer, even if HREADY misbehaves
   assign start      = HSEL & HREADY & (HTRANS inside {2'b10, 2'b11}) & ((state == IDLE) | complete);
   assign HRDATA     = RDATA_VALUE;
   assign keep_valid = fault_valid & ~fault_clr;
   assign cnt_base   = fault_clr ? '0 : fault_count;

   always_comb begin
      next = IDLE;
      case (state)
         WAIT:    next = (wait_cnt == 4'd0) ? RESP_ST : WAIT;
         ERR1:    next = ERR2;
         default: next = start ? FIRST_ST : IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state      <= IDLE;
         HREADYOUT  <= 1'b1;
         HRESP      <= 1'b0;
         wait_cnt   <= '0;
         pend_addr  <= '0;
         pend_write <= 1'b0;
         pend_size  <= '0;
      end else begin
         state     <= next;
         HREADYOUT <= (next == IDLE) || (next == ERR2) || (next == OKAY);
         HRESP     <= (next == ERR1) || (next == ERR2);
         wait_cnt  <= (state == WAIT) ? wait_cnt - 4'd1 : WAIT_LOAD;
         if (start) begin
            pend_addr  <= HADDR;
            pend_write <= HWRITE;
            pend_size  <= HSIZE;
         end
      end
   end

   // a clear coinciding with a completion wipes the old record before logging the new fault
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         fault_valid <= 1'b0;
         fault_ovf   <= 1'b0;
         fault_count <= '0;
         fault_addr  <= '0;
         fault_write <= 1'b0;
         fault_size  <= '0;
      end else if (complete) begin
         fault_count <= (&cnt_base) ? cnt_base : cnt_base + CNT_WIDTH'(1);
         fault_valid <= 1'b1;
         fault_ovf   <= ~fault_clr & (fault_ovf | fault_valid);
         if (!keep_valid) begin
            fault_addr  <= pend_addr;
            fault_write <= pend_write;
            fault_size  <= pend_size;
         end
      end else if (fault_clr) begin
         fault_valid <= 1'b0;
         fault_ovf   <= 1'b0;
         fault_count <= '0;
      end
   end
endmodule

// File: tb/tb_ahb3lite_fault_slave.sv
// tb_ahb3lite_fault_slave: four differently configured default slaves on a shared bus,
// checked against a response queue and a vector table of expected fault records.
module tb_ahb3lite_fault_slave;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  rst_n, hsel, fclr;
   logic        hold, hwrite;
   logic [31:0] haddr;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   wire  [3:0]  rdy, resp, fvalid, fovf, fwrite, hready_in;
   wire  [31:0] rdata [4];
   wire  [31:0] faddr [4];
   wire  [31:0] fcnt  [4];
   wire  [2:0]  fsize [4];

   assign hready_in = rdy & {4{~hold}};

   // dut0: ERR W=0, dut1: ERR W=3, dut2: OKAY W=2 0xDEADBEEF, dut3: ERR W=0 CNT_WIDTH=2
   for (genvar i = 0; i < 4; i++) begin : g_dut
      localparam int CW = (i == 3) ? 2 : 8;
      wire [CW-1:0] cnt;
      ahb3lite_fault_slave #(
         .ADDR_WIDTH(32), .DATA_WIDTH(32),
         .WAIT_STATES((i == 1) ? 3 : (i == 2) ? 2 : 0),
         .ERR_MODE(i != 2),
         .RDATA_VALUE((i == 2) ? 32'hDEAD_BEEF : 32'h0),
         .CNT_WIDTH(CW)
      ) dut (
         .CLK(clk), .RESETn(rst_n[i]), .HSEL(hsel[i]), .HADDR(haddr), .HWRITE(hwrite),
         .HSIZE(hsize), .HTRANS(htrans), .HREADY(hready_in[i]), .HREADYOUT(rdy[i]),
         .HRESP(resp[i]), .HRDATA(rdata[i]), .fault_clr(fclr[i]), .fault_valid(fvalid[i]),
         .fault_ovf(fovf[i]), .fault_addr(faddr[i]), .fault_write(fwrite[i]),
         .fault_size(fsize[i]), .fault_count(cnt)
      );
      assign fcnt[i] = 32'(cnt);
   end

   int ws[4] = '{0, 3, 2, 0};
   bit em[4] = '{1, 1, 0, 1};

   typedef struct {
      int   d;
      logic rdy;
      logic resp;
   } rsp_t;
   rsp_t q[$];

   typedef struct {
      int          d;
      bit          sel;
      logic [1:0]  tr;
      bit          hold;
      logic [31:0] a;
      bit          w;
      logic [2:0]  sz;
      int          cnt;
      bit          v;
      bit          o;
      logic [31:0] fa;
      bit          fw;
      logic [2:0]  fs;
   } vec_t;
   vec_t tbl[14];

   int n_vec = 0, n_err = 0;

   function automatic logic [31:0] rd_exp(input int d);
      return (d == 2) ? 32'hDEAD_BEEF : 32'h0;
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %h, want %h", nm, d, act, exp);
      end
   endtask

   task automatic chk_fault(input int d, input int cnt, input bit v, input bit o,
                            input logic [31:0] a, input bit w, input logic [2:0] s);
      chk("fault_count", d, fcnt[d], cnt);
      chk("fault_valid", d, 32'(fvalid[d]), 32'(v));
      chk("fault_ovf", d, 32'(fovf[d]), 32'(o));
      chk("fault_addr", d, faddr[d], a);
      chk("fault_write", d, 32'(fwrite[d]), 32'(w));
      chk("fault_size", d, 32'(fsize[d]), 32'(s));
   endtask

   task automatic push_resp(input int d);
      for (int k = 0; k < ws[d]; k++) q.push_back('{d, 1'b0, 1'b0});
      if (em[d]) begin
         q.push_back('{d, 1'b0, 1'b1});
         q.push_back('{d, 1'b1, 1'b1});
      end else q.push_back('{d, 1'b1, 1'b0});
   endtask

   task automatic check_pop();
      rsp_t e;
      @(negedge clk);
      e = q.pop_front();
      chk("hreadyout", e.d, 32'(rdy[e.d]), 32'(e.rdy));
      chk("hresp", e.d, 32'(resp[e.d]), 32'(e.resp));
      chk("hrdata", e.d, rdata[e.d], rd_exp(e.d));
   endtask

   task automatic idle_bus();
      hsel = '0; htrans = 2'b00; hold = 1'b0; hwrite = 1'b0;
   endtask

   task automatic addr_phase(input int d, input logic [31:0] a, input bit w, input logic [2:0] s);
      haddr = a; hwrite = w; hsize = s; htrans = 2'b10; hsel = 4'(1 << d);
   endtask

   task automatic run_vec(input vec_t v);
      @(posedge clk); #1;
      haddr = v.a; hwrite = v.w; hsize = v.sz; htrans = v.tr; hold = v.hold;
      hsel = v.sel ? 4'(1 << v.d) : 4'b0;
      if (v.sel && !v.hold && v.tr[1]) push_resp(v.d);
      else q.push_back('{v.d, 1'b1, 1'b0});
      @(posedge clk); #1;
      idle_bus();
      while (q.size() > 0) check_pop();
      @(negedge clk);
      chk_fault(v.d, v.cnt, v.v, v.o, v.fa, v.fw, v.fs);
   endtask

   initial begin
      rst_n = '0; fclr = '0; haddr = '0; hsize = '0;
      idle_bus();
      tbl = '{
         '{0, 1, 2'b10, 0, 32'h4000_0010, 0, 3'd2, 1, 1, 0, 32'h4000_0010, 0, 3'd2},
         '{0, 1, 2'b00, 0, 32'h4000_0020, 0, 3'd2, 1, 1, 0, 32'h4000_0010, 0, 3'd2},
         '{0, 1, 2'b01, 0, 32'h4000_0030, 1, 3'd2, 1, 1, 0, 32'h4000_0010, 0, 3'd2},
         '{0, 0, 2'b10, 0, 32'h0000_0055, 1, 3'd0, 1, 1, 0, 32'h4000_0010, 0, 3'd2},
         '{0, 1, 2'b10, 1, 32'h0000_0066, 1, 3'd1, 1, 1, 0, 32'h4000_0010, 0, 3'd2},
         '{1, 1, 2'b10, 0, 32'h2000_0004, 1, 3'd2, 1, 1, 0, 32'h2000_0004, 1, 3'd2},
         '{2, 1, 2'b10, 0, 32'h3000_0000, 0, 3'd2, 1, 1, 0, 32'h3000_0000, 0, 3'd2},
         '{2, 1, 2'b11, 0, 32'h3000_0008, 1, 3'd0, 2, 1, 1, 32'h3000_0000, 0, 3'd2},
         '{0, 1, 2'b11, 0, 32'h0000_0044, 1, 3'd1, 2, 1, 1, 32'h4000_0010, 0, 3'd2},
         '{3, 1, 2'b10, 0, 32'h0000_0010, 0, 3'd2, 1, 1, 0, 32'h0000_0010, 0, 3'd2},
         '{3, 1, 2'b10, 0, 32'h0000_0020, 0, 3'd2, 2, 1, 1, 32'h0000_0010, 0, 3'd2},
         '{3, 1, 2'b10, 0, 32'h0000_0030, 0, 3'd2, 3, 1, 1, 32'h0000_0010, 0, 3'd2},
         '{3, 1, 2'b10, 0, 32'h0000_0040, 0, 3'd2, 3, 1, 1, 32'h0000_0010, 0, 3'd2},
         '{3, 1, 2'b10, 0, 32'h0000_0050, 0, 3'd2, 3, 1, 1, 32'h0000_0010, 0, 3'd2}
      };
      repeat (2) @(posedge clk);
      #1 rst_n = '1;
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         chk("reset_hreadyout", d, 32'(rdy[d]), 32'd1);
         chk("reset_hresp", d, 32'(resp[d]), 32'd0);
         chk_fault(d, 0, 0, 0, 32'h0, 0, 3'd0);
      end

      for (int i = 0; i < 14; i++) run_vec(tbl[i]);

      // clear, then two back-to-back transfers with no idle gap
      @(posedge clk); #1 fclr[0] = 1'b1;
      @(posedge clk); #1 fclr[0] = 1'b0;
      @(negedge clk);
      chk_fault(0, 0, 0, 0, 32'h4000_0010, 0, 3'd2);
      @(posedge clk); #1 addr_phase(0, 32'h100, 0, 3'd2);
      @(posedge clk); #1 addr_phase(0, 32'h200, 1, 3'd2);
      push_resp(0);
      push_resp(0);
      check_pop();
      check_pop();
      @(posedge clk); #1 idle_bus();
      check_pop();
      check_pop();
      @(negedge clk);
      chk_fault(0, 2, 1, 1, 32'h100, 0, 3'd2);

      // sixth fault on the saturated counter, cleared on its completion edge
      @(posedge clk); #1 addr_phase(3, 32'h60, 1, 3'd1);
      @(posedge clk); #1 idle_bus();
      push_resp(3);
      check_pop();
      @(posedge clk); #1 fclr[3] = 1'b1;
      check_pop();
      @(posedge clk); #1 fclr[3] = 1'b0;
      @(negedge clk);
      chk_fault(3, 1, 1, 0, 32'h60, 1, 3'd1);

      // reset asserted during ERR1 drops the response and the pending fault
      @(posedge clk); #1 addr_phase(0, 32'hABC, 0, 3'd2);
      @(posedge clk); #1 idle_bus();
      @(negedge clk);
      chk("err1_hreadyout", 0, 32'(rdy[0]), 32'd0);
      chk("err1_hresp", 0, 32'(resp[0]), 32'd1);
      #1 rst_n[0] = 1'b0;
      #1;
      chk("async_rst_hreadyout", 0, 32'(rdy[0]), 32'd1);
      chk("async_rst_hresp", 0, 32'(resp[0]), 32'd0);
      @(negedge clk); #1 rst_n[0] = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_hreadyout", 0, 32'(rdy[0]), 32'd1);
      chk_fault(0, 0, 0, 0, 32'h0, 0, 3'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
